icache_line_fetch: RTL and testbench
====================================

Name: icache_line_fetch

Overview:
- Direct-mapped, read-only instruction cache. Sits between the instruction-fetch stage and the 128-bit line-read port of the unified RAM.
- Accepts 32-bit fetch requests. Hits return an instruction from the line store; misses initiate a 16-byte line read, wait a fixed latency, capture the line and answer the request.
- It is the initiator/reader side of the RAM's line-read port.

Parameters:
- ADDR_WIDTH, 17: byte-address width, matching the RAM.
- LINE_BYTES, 16: bytes per line. Fixed 16; sets the 128-bit line width.
- INDEX_BITS, 4: log2 of the line count (16 lines).
- MEM_LATENCY, 1: cycles between issuing mem_addr and sampling mem_line. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request.
- req_addr  in  ADDR_WIDTH  fetch byte address. Bits [1:0] are ignored.
- req_ready  out  1  cache can accept a request. High only in IDLE.
- resp_valid  out  1  one-cycle pulse: resp_inst is valid.
- resp_inst  out  32  fetched instruction.
- flush  in  1  invalidate all lines and abort any miss in flight.
- mem_addr  out  ADDR_WIDTH  line-aligned read address. Low 4 bits are always 0.
- mem_rd_en  out  1  read in progress.
- mem_line  in  128  line data. Byte k of the line is mem_line[127-8k -: 8].

Behaviour:
- Address split:
  - offset = req_addr[3:2] (word in line).
  - index = req_addr[3+INDEX_BITS:4].
  - tag = remaining upper bits.
- Instruction assembly is little-endian: resp_inst = {byte[4w+3], byte[4w+2], byte[4w+1], byte[4w]}, where w is the offset.
- Reset (async): state=IDLE, all valid bits=0, resp_valid=0, resp_inst=0, mem_rd_en=0, mem_addr=0, req_ready=1. Tag and data arrays are not reset.
- FSM states: IDLE, MISS_WAIT, RESPOND.
  - IDLE, req_valid, hit (valid[index] and tag match): next cycle resp_valid=1 with the instruction; stay IDLE. Back-to-back hits give one response per cycle; hit latency is 1.
  - IDLE, req_valid, miss: latch addr; mem_addr={tag,index,4'b0}; mem_rd_en=1; wait counter=MEM_LATENCY-1; go to MISS_WAIT.
  - MISS_WAIT: decrement the counter each cycle. In the cycle the counter is 0, write mem_line into data[index], set the tag, set valid[index]=1, drop mem_rd_en, go to RESPOND.
  - RESPOND: resp_valid=1 with the instruction from the latched addr; go to IDLE.
  - Miss latency is MEM_LATENCY+2 cycles from request to resp_valid.
- resp_valid is registered and high for exactly one cycle per accepted request. resp_inst holds its value between responses.
- req_ready=0 in MISS_WAIT and RESPOND. Requests presented while req_ready=0 are ignored; the requester must hold or re-issue them.
- Flush (highest priority):
  - Clears all valid bits in the next cycle.
  - In MISS_WAIT: aborts the miss, sets mem_rd_en=0, returns to IDLE, writes no line, issues no response.
  - In RESPOND: the response is suppressed.
  - In IDLE with req_valid: the request is dropped, with no response.
- Wrap-around: the index comes from the address, so no overflow is possible. An address at the top of memory fetches a line ending at 2^ADDR_WIDTH-1.
- The cache never writes memory; store coherence is handled by software issuing flush.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Counts increment on each accepted hit or miss, wrap at 2^32, reset to 0 by rst, and are not cleared by flush.
  - A flushed request counts as neither.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg:
  - Constants LINE_BITS=128 and OFFSET_BITS=4.
  - FSM state enum {IDLE, MISS_WAIT, RESPOND}.
  - Function extract_word(line, offset) implementing the byte order above.
- One sub-module, icache_tag_store: valid/tag/data arrays with async valid clear and single-port write, read combinationally by index.

Test Plan:
1. Reset, then request addr 0x00010 with mem holding bytes 13 00 00 93 at 0x10..0x13 (MEM_LATENCY=1) -> mem_rd_en high one cycle with mem_addr=0x00010; resp_valid 3 cycles after request; resp_inst=0x93000013.
2. After (1), requests 0x00014, 0x00018, 0x0001C on consecutive cycles -> three consecutive resp_valid pulses, each 1 cycle after its request; no mem_rd_en.
3. Conflict: request 0x00010 then 0x00110 (same index, different tag) -> both miss. Re-requesting 0x00010 misses again, with mem_addr=0x00010.
4. Flush asserted during MISS_WAIT (MEM_LATENCY=4) -> mem_rd_en drops next cycle; no resp_valid; req_ready=1; a following request to the same addr misses.
5. rst asserted mid-MISS_WAIT -> all outputs immediately at reset values; first post-reset request misses.
6. With ICACHE_PERF_CNT_EN: sequence miss, hit, hit, flush, miss -> hit_cnt=2, miss_cnt=2.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache line-fetch block.
//   LINE_BITS    : width of one cache line and of the RAM line-read port
//   OFFSET_BITS  : byte-offset bits within a line
//   state_e      : controller FSM states
//   extract_word : picks a 32-bit little-endian instruction out of a line
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RESPOND   = 2'd2
    } state_e;

    // Byte k of a line lives at line[127-8k -: 8]; word w covers bytes
    // 4w..4w+3, which is the 32-bit chunk line[127-32w -: 32] holding them
    // in ascending order. Instructions are little-endian, so the chunk is
    // byte-reversed on the way out.
    function automatic logic [31:0] extract_word(input logic [LINE_BITS-1:0] line,
                                                 input logic [1:0]           offset);
        logic [31:0] chunk;
        case (offset)
            2'd0:    chunk = line[127:96];
            2'd1:    chunk = line[95:64];
            2'd2:    chunk = line[63:32];
            default: chunk = line[31:0];
        endcase
        return {chunk[7:0], chunk[15:8], chunk[23:16], chunk[31:24]};
    endfunction

endpackage

// File: rtl/icache_line_fetch_if.sv
// -----------------------------------------------------------------------------
// icache_line_fetch_if
// Bundles the fetch-side request/response handshake, the flush strobe and
// the RAM line-read port of the instruction cache.
//   req_valid/req_addr/req_ready : fetch request handshake
//   resp_valid/resp_inst         : one-cycle response pulse + instruction
//   flush                        : invalidate all lines, abort miss
//   mem_addr/mem_rd_en/mem_line  : RAM line-read port (cache is initiator)
// Modports:
//   slave  : the cache itself (serves fetches, drives the RAM read)
//   master : the surrounding environment (fetch stage and RAM)
// -----------------------------------------------------------------------------
interface icache_line_fetch_if
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_inst;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [LINE_BITS-1:0]  mem_line;

    modport slave (
        input  req_valid, req_addr, flush, mem_line,
        output req_ready, resp_valid, resp_inst, mem_addr, mem_rd_en
    );

    modport master (
        output req_valid, req_addr, flush, mem_line,
        input  req_ready, resp_valid, resp_inst, mem_addr, mem_rd_en
    );

endinterface

// File: rtl/icache_tag_store.sv
// -----------------------------------------------------------------------------
// icache_tag_store
// Valid/tag/data arrays of the direct-mapped cache.
//   clk, rst   : clock, asynchronous active-high reset (valid bits only)
//   clear      : synchronous invalidate of every line (flush)
//   wr_en      : write wr_tag/wr_line into entry wr_index and mark it valid
//   rd_index   : combinational read port -> rd_valid, rd_tag, rd_line
// Tag and data arrays carry no reset; only the valid bits are initialised.
// -----------------------------------------------------------------------------
module icache_tag_store #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 9,
    parameter int LINE_W     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [LINE_W-1:0]     wr_line,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_W-1:0]     rd_line
);
    localparam int NLINES = 1 << INDEX_BITS;

    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] valid_d;
    logic [TAG_BITS-1:0] tag_mem  [NLINES];
    logic [LINE_W-1:0]   data_mem [NLINES];

    // Invalidate wins over a concurrent fill.
    always_comb begin
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache_line_fetch.sv
// -----------------------------------------------------------------------------
// icache_line_fetch
// Direct-mapped, read-only instruction cache between the fetch stage and the
// 128-bit line-read port of the unified RAM. Hits answer one cycle after the
// request; misses read a 16-byte line, wait MEM_LATENCY cycles, fill the
// line and answer MEM_LATENCY+2 cycles after the request.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous, active-high reset
//   bus      : icache_line_fetch_if.slave (request/response, flush, RAM port)
//   hit_cnt  : accepted-hit counter   (only with ICACHE_PERF_CNT_EN)
//   miss_cnt : accepted-miss counter  (only with ICACHE_PERF_CNT_EN)
// Build option: define ICACHE_PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module icache_line_fetch
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int LINE_BYTES  = 16,
    parameter int INDEX_BITS  = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    icache_line_fetch_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int TAG_BITS = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int CNT_W    = 4;

    // Registered state
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_inst_q, resp_inst_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    // Address fields of the incoming request and of the latched miss address
    logic [1:0]            req_off, lat_off;
    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [TAG_BITS-1:0]   req_tag, lat_tag;

    logic [INDEX_BITS-1:0] rd_index;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [LINE_W-1:0]     rd_line;

    logic hit;
    logic accept;
    logic acc_hit;
    logic acc_miss;
    logic fill_en;

    // Byte-select bits of the request are not used by a word fetch.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{bus.req_addr[1:0], addr_q[1:0]};

    assign req_off = bus.req_addr[OFFSET_BITS-1:2];
    assign req_idx = bus.req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag = bus.req_addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    assign lat_off = addr_q[OFFSET_BITS-1:2];
    assign lat_idx = addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign lat_tag = addr_q[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];

    // In IDLE the store is probed with the new request; otherwise it serves
    // the miss in flight (fill target and, in RESPOND, the freshly written line).
    assign rd_index = (state_q == IDLE) ? req_idx : lat_idx;

    assign hit      = rd_valid && (rd_tag == req_tag);
    assign accept   = (state_q == IDLE) && bus.req_valid && !bus.flush;
    assign acc_hit  = accept && hit;
    assign acc_miss = accept && !hit;

    icache_tag_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .LINE_W     (LINE_W)
    ) u_tag_store (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.flush),
        .wr_en    (fill_en),
        .wr_index (lat_idx),
        .wr_tag   (lat_tag),
        .wr_line  (bus.mem_line),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Next-state logic; flush returns MISS_WAIT to IDLE without a fill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_miss) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_inst_d  = resp_inst_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_addr_d   = mem_addr_q;
        fill_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_hit) begin
                    resp_valid_d = 1'b1;
                    resp_inst_d  = extract_word(rd_line, req_off);
                end
                if (acc_miss) begin
                    addr_d      = bus.req_addr;
                    mem_addr_d  = {bus.req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    mem_rd_en_d = 1'b1;
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                end
            end
            MISS_WAIT: begin
                if (bus.flush) begin
                    mem_rd_en_d = 1'b0;
                end else if (cnt_q == '0) begin
                    // mem_line is valid exactly MEM_LATENCY cycles after mem_addr.
                    fill_en     = 1'b1;
                    mem_rd_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                if (!bus.flush) begin
                    resp_valid_d = 1'b1;
                    resp_inst_d  = extract_word(rd_line, lat_off);
                end
            end
            default: begin
                mem_rd_en_d = 1'b0;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_inst  = resp_inst_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    // Counted at acceptance; flush is not a reset for these.
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q  + {31'd0, acc_hit};
        miss_cnt_d = miss_cnt_q + {31'd0, acc_miss};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_line_fetch.sv
// -----------------------------------------------------------------------------
// tb_icache_line_fetch
// Directed bench for icache_line_fetch. Two instances: dut1 with
// MEM_LATENCY=1 and dut4 with MEM_LATENCY=4, each with a byte-array RAM
// model that presents the line only in the cycle it must be sampled.
// Build option: ICACHE_PERF_CNT_EN also exercises the hit/miss counters.
// -----------------------------------------------------------------------------
module tb_icache_line_fetch;
    import icache_pkg::*;

    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    icache_line_fetch_if #(.ADDR_WIDTH(AW)) f1 ();
    icache_line_fetch_if #(.ADDR_WIDTH(AW)) f4 ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt1, miss_cnt1, hit_cnt4, miss_cnt4;
`endif

    icache_line_fetch #(
        .ADDR_WIDTH(AW), .LINE_BYTES(16), .INDEX_BITS(4), .MEM_LATENCY(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (f1)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt1),
        .miss_cnt (miss_cnt1)
`endif
    );

    icache_line_fetch #(
        .ADDR_WIDTH(AW), .LINE_BYTES(16), .INDEX_BITS(4), .MEM_LATENCY(4)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (f4)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt4),
        .miss_cnt (miss_cnt4)
`endif
    );

    // RAM model
    logic [7:0] mem [0:(1<<AW)-1];
    logic [3:0] lat1, lat4;

    function automatic logic [127:0] line_of(input logic [AW-1:0] a);
        logic [127:0] l;
        int base;
        base = int'({a[AW-1:4], 4'b0000});
        for (int k = 0; k < 16; k++) l[127-8*k -: 8] = mem[base+k];
        return l;
    endfunction

    always @(posedge clk) begin
        lat1 <= f1.mem_rd_en ? lat1 + 4'd1 : 4'd0;
        lat4 <= f4.mem_rd_en ? lat4 + 4'd1 : 4'd0;
    end

    assign f1.mem_line = (f1.mem_rd_en && lat1 == 4'd0) ? line_of(f1.mem_addr) : '0;
    assign f4.mem_line = (f4.mem_rd_en && lat4 == 4'd3) ? line_of(f4.mem_addr) : '0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    // Miss on dut1 (MEM_LATENCY=1): response 3 cycles after the request.
    task automatic do_miss(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [AW-1:0] la;
        la = {a[AW-1:4], 4'b0000};
        f1.req_valid = 1'b1;
        f1.req_addr  = a;
        tick();
        f1.req_valid = 1'b0;
        check({tag, "_rd_en"}, f1.mem_rd_en, 1);
        check({tag, "_mem_addr"}, f1.mem_addr, la);
        check({tag, "_ready_lo"}, f1.req_ready, 0);
        tick();
        check({tag, "_rd_en_drop"}, f1.mem_rd_en, 0);
        check({tag, "_no_early_resp"}, f1.resp_valid, 0);
        tick();
        check({tag, "_resp_valid"}, f1.resp_valid, 1);
        check({tag, "_resp_inst"}, f1.resp_inst, exp);
    endtask

    // Hit on dut1: response 1 cycle after the request, no RAM access.
    task automatic do_hit(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        f1.req_valid = 1'b1;
        f1.req_addr  = a;
        tick();
        f1.req_valid = 1'b0;
        check({tag, "_resp_valid"}, f1.resp_valid, 1);
        check({tag, "_resp_inst"}, f1.resp_inst, exp);
        check({tag, "_no_rd_en"}, f1.mem_rd_en, 0);
    endtask

    initial begin
        int pulses;
        rst          = 1'b1;
        f1.req_valid = 1'b0; f1.req_addr = '0; f1.flush = 1'b0;
        f4.req_valid = 1'b0; f4.req_addr = '0; f4.flush = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i ^ (i >> 8));
        mem[16] = 8'h13; mem[17] = 8'h00; mem[18] = 8'h00; mem[19] = 8'h93;
        set_word('h14, 32'h00a00093);
        set_word('h18, 32'h00b00113);
        set_word('h1C, 32'h002081b3);
        set_word('h110, 32'hdeadbeef);
        set_word('h1FFF0, 32'h0badf00d);
        set_word('h1FFFC, 32'hcafef00d);
        set_word('h20, 32'h12345678);
        set_word('h30, 32'h0fedcba9);

        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_ready", f1.req_ready, 1);
        check("rst_resp_valid", f1.resp_valid, 0);
        check("rst_resp_inst", f1.resp_inst, 0);
        check("rst_rd_en", f1.mem_rd_en, 0);
        check("rst_mem_addr", f1.mem_addr, 0);
`ifdef ICACHE_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt1, 0);
        check("rst_miss_cnt", miss_cnt1, 0);
`endif

        // First miss, then back-to-back hits in the same line
        do_miss("t1", 17'h00010, 32'h93000013);
        do_hit("t2a", 17'h00014, 32'h00a00093);
        do_hit("t2b", 17'h00018, 32'h00b00113);
        do_hit("t2c", 17'h0001C, 32'h002081b3);
        tick();
        check("t2_resp_drop", f1.resp_valid, 0);
        check("t2_resp_hold", f1.resp_inst, 32'h002081b3);

        // Conflict on index 1
        do_miss("t3a", 17'h00110, 32'hdeadbeef);
        do_miss("t3b", 17'h00010, 32'h93000013);

        // Top-of-memory line
        do_miss("wrap", 17'h1FFFC, 32'hcafef00d);
        do_hit("wrap_hit", 17'h1FFF0, 32'h0badf00d);

        // Flush together with a would-be hit in IDLE drops it
        f1.req_valid = 1'b1; f1.req_addr = 17'h00014; f1.flush = 1'b1;
        tick();
        f1.req_valid = 1'b0; f1.flush = 1'b0;
        check("flush_idle_no_resp", f1.resp_valid, 0);
        check("flush_idle_no_rd", f1.mem_rd_en, 0);
        do_miss("after_flush", 17'h00014, 32'h00a00093);

        // Flush during MISS_WAIT on dut4
        f4.req_valid = 1'b1; f4.req_addr = 17'h00020;
        tick();
        f4.req_valid = 1'b0;
        check("t4_rd_en", f4.mem_rd_en, 1);
        check("t4_mem_addr", f4.mem_addr, 17'h00020);
        tick();
        f4.flush = 1'b1;
        tick();
        f4.flush = 1'b0;
        check("t4_rd_en_drop", f4.mem_rd_en, 0);
        check("t4_ready", f4.req_ready, 1);
        check("t4_no_resp", f4.resp_valid, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (f4.resp_valid) pulses++;
        end
        check("t4_no_late_resp", pulses, 0);
        f4.req_valid = 1'b1; f4.req_addr = 17'h00020;
        tick();
        f4.req_valid = 1'b0;
        check("t4_remiss", f4.mem_rd_en, 1);
        tick(); tick(); tick();
        check("t4_rd_en_c4", f4.mem_rd_en, 1);
        tick();
        check("t4_rd_en_c5", f4.mem_rd_en, 0);
        check("t4_resp_c5", f4.resp_valid, 0);
        tick();
        check("t4_resp_c6", f4.resp_valid, 1);
        check("t4_inst", f4.resp_inst, 32'h12345678);
        f4.req_valid = 1'b1; f4.req_addr = 17'h00024;
        tick();
        f4.req_valid = 1'b0;
        check("t4_hit_valid", f4.resp_valid, 1);
        check("t4_hit_inst", f4.resp_inst, {8'(16'h27 ^ 16'h0), 8'h26, 8'h25, 8'h24});
        check("t4_hit_no_rd", f4.mem_rd_en, 0);

        // Reset in the middle of MISS_WAIT
        f4.req_valid = 1'b1; f4.req_addr = 17'h00030;
        tick();
        f4.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("t5_rd_en", f4.mem_rd_en, 0);
        check("t5_mem_addr", f4.mem_addr, 0);
        check("t5_ready", f4.req_ready, 1);
        check("t5_resp_valid", f4.resp_valid, 0);
        check("t5_resp_inst", f4.resp_inst, 0);
        tick();
        rst = 1'b0;
        tick();
        f4.req_valid = 1'b1; f4.req_addr = 17'h00030;
        tick();
        f4.req_valid = 1'b0;
        check("t5_post_miss", f4.mem_rd_en, 1);
        check("t5_post_addr", f4.mem_addr, 17'h00030);
        tick(); tick(); tick(); tick(); tick();
        check("t5_post_resp", f4.resp_valid, 1);
        check("t5_post_inst", f4.resp_inst, 32'h0fedcba9);

        // Counter sequence on dut1 after the reset: miss, hit, hit, flush, miss
        do_miss("t6a", 17'h00010, 32'h93000013);
        do_hit("t6b", 17'h00014, 32'h00a00093);
        do_hit("t6c", 17'h00018, 32'h00b00113);
        f1.flush = 1'b1;
        tick();
        f1.flush = 1'b0;
        check("t6_flush_resp", f1.resp_valid, 0);
        do_miss("t6d", 17'h00010, 32'h93000013);
`ifdef ICACHE_PERF_CNT_EN
        check("t6_hit_cnt", hit_cnt1, 2);
        check("t6_miss_cnt", miss_cnt1, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
